// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes, ARM register
// indices and the write-port select type used by write decode and read bypass.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NRD_DEF    = 3;

  localparam int R_SP = 13;
  localparam int R_LR = 14;
  localparam int R_PC = 15;

  typedef enum logic [1:0] {
    WP_NONE,
    WP_W0,
    WP_W1
  } wp_sel_e;

  // W0 outranks W1 whenever both hit the same register.
  function automatic wp_sel_e wp_select(input logic w0_hit, input logic w1_hit);
    if (w0_hit) return WP_W0;
    else if (w1_hit) return WP_W1;
    else return WP_NONE;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read lane: array mux, busy lookup and, when
// REGFILE_MP_BYPASS_EN is defined, forwarding from the two write ports.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]      raddr,
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   busy_vec,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic                   w0_en,
  input  logic [ADDR_W-1:0]      w0_addr,
  input  logic [DATA_W-1:0]      w0_data,
  input  logic                   w1_en,
  input  logic [ADDR_W-1:0]      w1_addr,
  input  logic [DATA_W-1:0]      w1_data,
  input  logic                   busy_set_en,
  input  logic [ADDR_W-1:0]      busy_set_addr,
`endif
  output logic [DATA_W-1:0]      rdata,
  output logic                   rbusy
);

  always_comb begin
    rdata = regs[raddr];
    rbusy = busy_vec[raddr];
`ifdef REGFILE_MP_BYPASS_EN
    case (wp_select(w0_en && (w0_addr == raddr), w1_en && (w1_addr == raddr)))
      WP_W0:   rdata = w0_data;
      WP_W1:   rdata = w1_data;
      default: ;
    endcase
    // A load landing this cycle releases the stall unless a new load reissues it.
    if (w1_en && (w1_addr == raddr) && !(busy_set_en && (busy_set_addr == raddr)))
      rbusy = 1'b0;
`endif
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NRD read lanes and a per-register
// busy scoreboard. Optional write-to-read forwarding under REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  localparam int NREG  = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w0_en,
  input  logic [ADDR_W-1:0]     w0_addr,
  input  logic [DATA_W-1:0]     w0_data,
  input  logic                  w1_en,
  input  logic [ADDR_W-1:0]     w1_addr,
  input  logic [DATA_W-1:0]     w1_data,
  input  logic                  busy_set_en,
  input  logic [ADDR_W-1:0]     busy_set_addr,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  output logic [NREG-1:0]       busy_vec,
  output logic                  collision
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  // W0 wins a same-register collision, so W1 data is simply never selected there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case (wp_select(w0_en && (w0_addr == ADDR_W'(i)), w1_en && (w1_addr == ADDR_W'(i))))
          WP_W0:   regs[i] <= w0_data;
          WP_W1:   regs[i] <= w1_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (busy_set_en) set_mask[busy_set_addr] = 1'b1;
    if (w1_en)       clr_mask[w1_addr]       = 1'b1;
  end

  // Set is applied after clear so a reissued load keeps its register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec  <= '0;
      collision <= 1'b0;
    end else begin
      busy_vec  <= (busy_vec & ~clr_mask) | set_mask;
      collision <= w0_en && w1_en && (w0_addr == w1_addr);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [DATA_W-1:0] lane_data;
    logic              lane_busy;

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .raddr         (raddr[k*ADDR_W +: ADDR_W]),
      .regs          (regs),
      .busy_vec      (busy_vec),
`ifdef REGFILE_MP_BYPASS_EN
      .w0_en         (w0_en),
      .w0_addr       (w0_addr),
      .w0_data       (w0_data),
      .w1_en         (w1_en),
      .w1_addr       (w1_addr),
      .w1_data       (w1_data),
      .busy_set_en   (busy_set_en),
      .busy_set_addr (busy_set_addr),
`endif
      .rdata         (lane_data),
      .rbusy         (lane_busy)
    );

    // Forwarding must not leak write data onto the read lanes while reset is held.
    assign rdata[k*DATA_W +: DATA_W] = rst_n ? lane_data : '0;
    assign rbusy[k]                  = rst_n ? lane_busy : 1'b0;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read REGFILE in the ARM core.
- Configurable data width, register count and read-port count.
- Two write ports: W0 for ALU/execute results, W1 for load writeback.
- Per-register busy scoreboard, so decode can stall on outstanding loads.
- Sits between decode (read/scoreboard) and the execute/memory writeback stages.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; NREG = 2**ADDR_W registers
NRD, 3, number of read ports (Rn, Rm, Rs)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
W0_EN  in  1  write port 0 enable (execute result)
W0_ADDR  in  ADDR_W  write port 0 register index
W0_DATA  in  DATA_W  write port 0 data
W1_EN  in  1  write port 1 enable (load writeback); also clears busy bit
W1_ADDR  in  ADDR_W  write port 1 register index
W1_DATA  in  DATA_W  write port 1 data
BUSY_SET_EN  in  1  mark a register as pending load
BUSY_SET_ADDR  in  ADDR_W  register index to mark busy
RADDR  in  NRD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
RDATA  out  NRD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W]
RBUSY  out  NRD  busy bit of the register addressed by each read port
BUSY_VEC  out  NREG  full scoreboard vector
COLLISION  out  1  registered flag: W0 and W1 targeted the same register last cycle

Behaviour:
- Reset (RST_N low, async): all NREG registers = 0, BUSY_VEC = 0, COLLISION = 0. RDATA reads 0 and RBUSY is 0 while reset is held. Reset wins over any write in the same cycle.
- Writes are synchronous on the CLK rising edge. W0 and W1 are independent when addresses differ.
- Write collision (W0_EN & W1_EN & W0_ADDR==W1_ADDR): W0_DATA is stored; W1_DATA is dropped. COLLISION = 1 on the following cycle, 0 otherwise (single-cycle pulse per colliding edge).
- Reads are combinational from the array; zero-cycle latency. Without bypass, a write becomes visible on RDATA the cycle after its edge.
- Scoreboard, per edge:
  - BUSY_SET_EN sets BUSY_VEC[BUSY_SET_ADDR].
  - W1_EN clears BUSY_VEC[W1_ADDR].
  - Same register set and cleared in one cycle: set wins (a new load is issued).
  - W0 never touches busy bits.
- RBUSY[k] = BUSY_VEC[RADDR_k] (combinational); BUSY_VEC is the registered vector.
- All ports read the same address: identical data on every lane.
- Index arithmetic unsigned; NREG always a power of two, so no out-of-range addresses exist.
- Reset released mid-stream: first edge after deassertion performs normal writes; no recovery cycle.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If W0_EN and RADDR_k==W0_ADDR, RDATA_k = W0_DATA in the same cycle.
  - Else if W1_EN and RADDR_k==W1_ADDR, RDATA_k = W1_DATA.
  - W0 priority matches the write-collision rule.
  - RBUSY_k is also forced 0 when W1 is writing that register, unless BUSY_SET_EN targets it in the same cycle.
- Undefined: no forwarding; RDATA/RBUSY reflect stored state only.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W/NRD constants;
  - register index constants (R_SP=13, R_LR=14, R_PC=15);
  - a write-port-select enum (WP_NONE, WP_W0, WP_W1), used for bypass muxing and collision decode.
- One natural sub-module: regfile_rd_port. It does a single read lane (array mux + optional bypass + busy lookup) and is instantiated NRD times in a generate loop.
- Array, write logic and scoreboard stay in the top.

Test Plan:
1. Reset then readback: hold RST_N low 2 cycles, release, RADDR={0,7,15} -> RDATA all 0, RBUSY=000, BUSY_VEC=0, COLLISION=0.
2. Fill and read: W0 writes value i+1 to Ri for i=0..15, then read R1/R5/R15 -> 2, 6, 16. Dual write in one cycle: W0 R3=0xAA, W1 R4=0xBB -> next cycle R3=0xAA, R4=0xBB.
3. Collision: W0 and W1 both to R9 with 0x11/0x22 -> R9=0x11 next cycle, COLLISION=1 for exactly one cycle.
4. Scoreboard sequence:
   - BUSY_SET R6 -> BUSY_VEC[6]=1, RBUSY=1 on a port reading R6.
   - W1 writes R6=0x55 -> busy clears next cycle.
   - Set and W1-clear R6 in the same cycle -> stays 1.
5. Bypass:
   - Macro defined: W0_EN R2=0x1234 while RADDR0=2 -> RDATA0=0x1234 in the same cycle.
   - Macro undefined: RDATA0 shows the old value that cycle, 0x1234 the next.
6. Async reset mid-operation: assert RST_N low between edges after R8=0x77 with R8 busy -> RDATA reads 0 and BUSY_VEC=0 immediately, without waiting for a CLK edge.
